// File: rtl/rat_pkg.sv
// Shared definitions for the rational-arithmetic blocks (mul, add, div).
package rat_pkg;

   localparam int unsigned DefaultWidth = 32;

   typedef struct packed {
      logic [DefaultWidth-1:0] num;
      logic [DefaultWidth-1:0] den;
   } rat_t;

endpackage

// File: rtl/mul_core.sv
// Unsigned WIDTH x WIDTH multiplier producing the full 2*WIDTH product.
module mul_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] p_o
);

   // Zero-extend first so the product is formed at full width.
   assign p_o = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

endmodule

// File: rtl/mul.sv
// Registered component-wise rational multiply: s = l * r, unreduced, one-cycle latency.
// Define MUL_OVF_EN to add a registered ovf output flagging truncated products.
module mul
   import rat_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] l_num,
   input  logic [WIDTH-1:0] l_den,
   input  logic [WIDTH-1:0] r_num,
   input  logic [WIDTH-1:0] r_den,
   output logic [WIDTH-1:0] s_num,
   output logic [WIDTH-1:0] s_den,
   input  logic             rst
`ifdef MUL_OVF_EN
   ,
   output logic             ovf
`endif
);

   logic [2*WIDTH-1:0] prod_num;
   logic [2*WIDTH-1:0] prod_den;
   logic [WIDTH-1:0]   s_num_d, s_num_q;
   logic [WIDTH-1:0]   s_den_d, s_den_q;

   mul_core #(
      .WIDTH (WIDTH)
   ) u_num_core (
      .a_i (l_num),
      .b_i (r_num),
      .p_o (prod_num)
   );

   mul_core #(
      .WIDTH (WIDTH)
   ) u_den_core (
      .a_i (l_den),
      .b_i (r_den),
      .p_o (prod_den)
   );

   always_comb begin
      s_num_d = prod_num[WIDTH-1:0];
      s_den_d = prod_den[WIDTH-1:0];
   end

   // Reset value is the rational 0/1.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_num_q <= '0;
         s_den_q <= WIDTH'(1);
      end else begin
         s_num_q <= s_num_d;
         s_den_q <= s_den_d;
      end
   end

   assign s_num = s_num_q;
   assign s_den = s_den_q;

`ifdef MUL_OVF_EN
   logic ovf_d, ovf_q;

   always_comb begin
      ovf_d = (|prod_num[2*WIDTH-1:WIDTH]) | (|prod_den[2*WIDTH-1:WIDTH]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   // Upper product halves are discarded when overflow reporting is off.
   logic unused_hi;
   assign unused_hi = ^{prod_num[2*WIDTH-1:WIDTH], prod_den[2*WIDTH-1:WIDTH]};
`endif

endmodule

// File: tb/tb_mul.sv
// Scoreboard bench for mul: driver queues expected products, a negedge monitor checks them.
module tb_mul;
   import rat_pkg::*;

   localparam int unsigned W = 32;

   typedef struct {
      string      name;
      rat_t       val;
      logic       ovf;
   } exp_t;

   logic         clk;
   logic         rst;
   logic [W-1:0] l_num, l_den, r_num, r_den;
   logic [W-1:0] s_num, s_den;
`ifdef MUL_OVF_EN
   logic         ovf;
`endif

   exp_t q[$];
   int   checks;
   int   failures;

   mul #(
      .WIDTH (W)
   ) dut (
      .clk   (clk),
      .l_num (l_num),
      .l_den (l_den),
      .r_num (r_num),
      .r_den (r_den),
      .s_num (s_num),
      .s_den (s_den),
      .rst   (rst)
`ifdef MUL_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on negedge; expected result is queued at the sampling posedge.
   task automatic issue(input string name, input logic r,
                        input logic [W-1:0] ln, input logic [W-1:0] ld,
                        input logic [W-1:0] rn, input logic [W-1:0] rd,
                        input logic [W-1:0] en, input logic [W-1:0] ed,
                        input logic eo);
      exp_t e;
      @(negedge clk);
      rst   = r;
      l_num = ln;
      l_den = ld;
      r_num = rn;
      r_den = rd;
      @(posedge clk);
      e.name    = name;
      e.val.num = en;
      e.val.den = ed;
      e.ovf     = eo;
      q.push_back(e);
   endtask

   task automatic issue_rand(input string name);
      logic [W-1:0] ln, ld, rn, rd;
      ln = W'($urandom_range(999, 0));
      ld = W'($urandom_range(999, 0));
      rn = W'($urandom_range(999, 0));
      rd = W'($urandom_range(999, 0));
      // Components below 1000 keep products under 2^20, so no truncation.
      issue(name, 1'b0, ln, ld, rn, rd, ln * rn, ld * rd, 1'b0);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic bad;
         e = q.pop_front();
         checks = checks + 1;
         bad = (s_num !== e.val.num) || (s_den !== e.val.den);
`ifdef MUL_OVF_EN
         bad = bad || (ovf !== e.ovf);
         if (bad) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d/%0d ovf=%b, expected %0d/%0d ovf=%b",
                     e.name, s_num, s_den, ovf, e.val.num, e.val.den, e.ovf);
         end
`else
         if (bad) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d/%0d, expected %0d/%0d",
                     e.name, s_num, s_den, e.val.num, e.val.den);
         end
`endif
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      rst   = 1'b1;
      l_num = '0;
      l_den = '0;
      r_num = '0;
      r_den = '0;

      issue("reset0", 1'b1, 32'd7, 32'd8, 32'd9, 32'd10, 32'd0, 32'd1, 1'b0);
      issue("reset1", 1'b1, 32'd7, 32'd8, 32'd9, 32'd10, 32'd0, 32'd1, 1'b0);

      issue("3/4*5/7", 1'b0, 32'd3, 32'd4, 32'd5, 32'd7, 32'd15, 32'd28, 1'b0);
      issue("zero_den", 1'b0, 32'd0, 32'd999, 32'd123, 32'd0, 32'd0, 32'd0, 1'b0);
      issue("num_wrap_0x10000", 1'b0, 32'h0001_0000, 32'd1, 32'h0001_0000, 32'd1,
            32'd0, 32'd1, 1'b1);
      issue("num_wrap_max_x2", 1'b0, 32'hFFFF_FFFF, 32'd6, 32'd2, 32'd5,
            32'hFFFF_FFFE, 32'd30, 1'b1);
      issue("den_wrap", 1'b0, 32'd2, 32'h0001_0000, 32'd3, 32'h0001_0000,
            32'd6, 32'd0, 1'b1);
      issue("no_reduce_2/4*2/4", 1'b0, 32'd2, 32'd4, 32'd2, 32'd4, 32'd4, 32'd16, 1'b0);

      for (int i = 0; i < 20; i++) issue_rand($sformatf("rand%0d", i));

      for (int i = 0; i < 3; i++) issue_rand($sformatf("pre_rst%0d", i));
      issue("mid_reset", 1'b1, 32'd11, 32'd12, 32'd13, 32'd14, 32'd0, 32'd1, 1'b0);
      issue("post_rst_first", 1'b0, 32'd11, 32'd12, 32'd13, 32'd14, 32'd143, 32'd168, 1'b0);
      for (int i = 0; i < 3; i++) issue_rand($sformatf("post_rst%0d", i));

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      @(posedge clk);
      if (q.size() > 0) begin
         failures = failures + 1;
         $display("FAIL drain: %0d results outstanding, expected 0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
